// File: rtl/vrb_pkg.sv
// Shared definitions for the vrb command/response bus responder.
// Holds the FSM state enum, response-error encoding and lane-count helper.
package vrb_pkg;

    // Width of the wait-state counter; WAIT_CYCLES ranges over 0..15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } vrb_state_t;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } vrb_rsp_err_t;

    // Number of byte lanes in a DW-bit word.
    function automatic int vrb_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/vrb_sram_slave_sram_1p.sv
// Single-port SRAM: byte write enables, synchronous read, DEPTH x DW.
// Ports: clk; i_re read strobe; i_we per-byte write enable; i_addr word
// index; i_wdata write data; o_rdata read data, held until the next read.
module sram_1p
    import vrb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    parameter int IW    = 12
) (
    input  logic                      clk,
    input  logic                      i_re,
    input  logic [vrb_lanes(DW)-1:0]  i_we,
    input  logic [IW-1:0]             i_addr,
    input  logic [DW-1:0]             i_wdata,
    output logic [DW-1:0]             o_rdata
);

    localparam int NB = vrb_lanes(DW);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Array contents and the read register are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vrb_sram_slave.sv
// vrb responder: single-beat read/write commands onto a private SRAM,
// one registered response per command after 1+WAIT_CYCLES cycles.
// Ports: clk, rst (async, active-high); i_vrb_cmd_* command (valid, addr,
// read, wdata, wmask); o_vrb_rsp_* response (valid, err, rdata); o_busy.
// Build option: define VRB_SRAM_ERR_EN to flag out-of-range or unaligned
// addresses as errors; otherwise the index simply wraps and err is 0.
module vrb_sram_slave
    import vrb_pkg::*;
#(
    parameter int             AW          = 32,
    parameter int             DW          = 32,
    parameter int             DEPTH       = 4096,
    parameter logic [AW-1:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int             WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_vrb_cmd_valid,
    input  logic [AW-1:0]             i_vrb_cmd_addr,
    input  logic                      i_vrb_cmd_read,
    input  logic [DW-1:0]             i_vrb_cmd_wdata,
    input  logic [vrb_lanes(DW)-1:0]  i_vrb_cmd_wmask,
    output logic                      o_vrb_rsp_valid,
    output logic                      o_vrb_rsp_err,
    output logic [DW-1:0]             o_vrb_rsp_rdata,
    output logic                      o_busy
);

    localparam int NB  = vrb_lanes(DW);
    localparam int LSB = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    vrb_state_t          r_state;
    vrb_state_t          w_next;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WAIT_W-1:0]   w_cnt_nxt;
    logic                r_read;
    logic                r_err;

    logic                w_accept;
    logic                w_resp;
    logic                w_err;
    logic [AW-1:0]       w_offset;
    logic [IW-1:0]       w_index;
    logic                w_sram_re;
    logic [NB-1:0]       w_sram_we;
    logic [DW-1:0]       w_sram_q;

    // Commands are only looked at in IDLE; later changes are ignored.
    assign w_accept = (r_state == ST_IDLE) && i_vrb_cmd_valid;

    // BASE_ADDR is DEPTH-aligned, so the offset bits above the index
    // carry only range information; dropping them wraps modulo DEPTH.
    assign w_offset = i_vrb_cmd_addr - BASE_ADDR;
    assign w_index  = w_offset[LSB +: IW];

`ifdef VRB_SRAM_ERR_EN
    localparam logic [AW:0]   SPAN     = (AW+1)'(DEPTH * NB);
    localparam logic [AW-1:0] LOW_MASK = AW'(NB - 1);

    // An address below BASE_ADDR wraps to a huge offset, so a single
    // upper-bound compare covers both ends of the window.
    assign w_err = ({1'b0, w_offset} >= SPAN)
                || ((i_vrb_cmd_addr & LOW_MASK) != '0);
`else
    logic w_unused_offset;

    assign w_err           = 1'b0;
    assign w_unused_offset = ^w_offset;
`endif

    // Write commits at the accept edge; read data appears one edge later.
    assign w_sram_re = w_accept && i_vrb_cmd_read && !w_err;
    assign w_sram_we = (w_accept && !i_vrb_cmd_read && !w_err)
                     ? i_vrb_cmd_wmask : '0;

    sram_1p #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_sram (
        .clk     (clk),
        .i_re    (w_sram_re),
        .i_we    (w_sram_we),
        .i_addr  (w_index),
        .i_wdata (i_vrb_cmd_wdata),
        .o_rdata (w_sram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_resp    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_vrb_cmd_valid) begin
                    w_cnt_nxt = WAIT_LD;
                    w_next    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt <= CNT_ONE) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp    = 1'b1;
                w_cnt_nxt = '0;
                w_next    = ST_IDLE;
            end
            default: begin
                w_cnt_nxt = '0;
                w_next    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_read <= i_vrb_cmd_read;
            r_err  <= w_err;
        end
    end

    // The RESP state is the cycle in which the response register loads;
    // the strobe itself is visible the cycle after. For reads, w_sram_q
    // has been stable since the edge after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vrb_rsp_valid <= 1'b0;
            o_vrb_rsp_err   <= RSP_OK;
            o_vrb_rsp_rdata <= '0;
            o_busy          <= 1'b0;
        end else begin
            o_vrb_rsp_valid <= w_resp;
            o_vrb_rsp_err   <= (w_resp && r_err) ? RSP_ERR : RSP_OK;
            o_vrb_rsp_rdata <= (w_resp && r_read && !r_err)
                             ? w_sram_q : '0;
            o_busy          <= (w_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vrb_sram_slave.sv
// Bench for vrb_sram_slave: two instances (WAIT_CYCLES 0 and 3, DEPTH 1024)
// against a transaction-level model plus hand-computed literal checks.
module tb_vrb_sram_slave;

    logic        clk;
    logic        rst;
    logic        cmd_valid [2];
    logic [31:0] cmd_addr  [2];
    logic        cmd_read  [2];
    logic [31:0] cmd_wdata [2];
    logic [3:0]  cmd_wmask [2];
    logic        o_valid   [2];
    logic        o_err     [2];
    logic [31:0] o_rdata   [2];
    logic        o_busy    [2];

    int n_tests = 0;
    int n_fail  = 0;

    vrb_sram_slave #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk             (clk),
        .rst             (rst),
        .i_vrb_cmd_valid (cmd_valid[0]),
        .i_vrb_cmd_addr  (cmd_addr[0]),
        .i_vrb_cmd_read  (cmd_read[0]),
        .i_vrb_cmd_wdata (cmd_wdata[0]),
        .i_vrb_cmd_wmask (cmd_wmask[0]),
        .o_vrb_rsp_valid (o_valid[0]),
        .o_vrb_rsp_err   (o_err[0]),
        .o_vrb_rsp_rdata (o_rdata[0]),
        .o_busy          (o_busy[0])
    );

    vrb_sram_slave #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk             (clk),
        .rst             (rst),
        .i_vrb_cmd_valid (cmd_valid[1]),
        .i_vrb_cmd_addr  (cmd_addr[1]),
        .i_vrb_cmd_read  (cmd_read[1]),
        .i_vrb_cmd_wdata (cmd_wdata[1]),
        .i_vrb_cmd_wmask (cmd_wmask[1]),
        .o_vrb_rsp_valid (o_valid[1]),
        .o_vrb_rsp_err   (o_err[1]),
        .o_vrb_rsp_rdata (o_rdata[1]),
        .o_busy          (o_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef VRB_SRAM_ERR_EN
        return (a >= 32'h1000) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_ix(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
        end
    endtask

    // Model: one outstanding command per instance; the response is due
    // 1+W edges after accept and the slave is free again 2+W edges after.
    logic [31:0] mm [2][1024];
    bit          outst   [2];
    int          acc     [2];
    bit          m_err   [2];
    bit          m_read  [2];
    logic [31:0] m_data  [2];
    bit          ex_valid[2];
    bit          ex_busy [2];
    bit          ex_err  [2];
    logic [31:0] ex_rdata[2];
    int          cyc = 0;

    always @(posedge clk) begin : model
        bit          o, e, rd, due;
        int          a, ix;
        logic [31:0] w, dat;
        for (int d = 0; d < 2; d++) begin
            o = outst[d]; a = acc[d]; e = m_err[d];
            rd = m_read[d]; dat = m_data[d];
            if (rst) begin
                o = 1'b0;
            end else begin
                if (o && cyc >= a + 2 + wc(d)) o = 1'b0;
                if (!o && cmd_valid[d]) begin
                    o  = 1'b1;
                    a  = cyc;
                    rd = cmd_read[d];
                    e  = addr_bad(cmd_addr[d]);
                    ix = word_ix(cmd_addr[d]);
                    w  = mm[d][ix];
                    dat = (rd && !e) ? w : 32'h0;
                    if (!rd && !e) begin
                        for (int b = 0; b < 4; b++)
                            if (cmd_wmask[d][b]) w[b*8 +: 8] = cmd_wdata[d][b*8 +: 8];
                        mm[d][ix] <= w;
                    end
                end
            end
            due = o && (cyc == a + 1 + wc(d));
            outst[d]    <= o;
            acc[d]      <= a;
            m_err[d]    <= e;
            m_read[d]   <= rd;
            m_data[d]   <= dat;
            ex_busy[d]  <= o && (cyc <= a + wc(d));
            ex_valid[d] <= due;
            ex_rdata[d] <= due ? dat : 32'h0;
            ex_err[d]   <= due && e;
        end
        cyc <= cyc + 1;
    end

    int vcnt [2] = '{0, 0};
    int bcnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_valid", d, 32'(o_valid[d]), 32'h0);
                chk("rst_busy",  d, 32'(o_busy[d]),  32'h0);
                chk("rst_err",   d, 32'(o_err[d]),   32'h0);
                chk("rst_rdata", d, o_rdata[d],      32'h0);
            end else begin
                chk("rsp_valid", d, 32'(o_valid[d]), 32'(ex_valid[d]));
                chk("busy",      d, 32'(o_busy[d]),  32'(ex_busy[d]));
                if (ex_valid[d]) begin
                    chk("rsp_err",   d, 32'(o_err[d]), 32'(ex_err[d]));
                    chk("rsp_rdata", d, o_rdata[d],    ex_rdata[d]);
                end
            end
            if (o_valid[d]) vcnt[d]++;
            if (o_busy[d])  bcnt[d]++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one command and wait (bounded) for its response; lat counts
    // edges from the first edge that sees cmd_valid to the response edge.
    task automatic cmd(input string name, input int d,
                       input logic [31:0] a, input bit rd,
                       input logic [31:0] wd, input logic [3:0] m,
                       input bit hold, input logic [31:0] exp_q,
                       input bit exp_e, input int exp_lat);
        int lat;
        cmd_valid[d] = 1'b1;
        cmd_addr[d]  = a;
        cmd_read[d]  = rd;
        cmd_wdata[d] = wd;
        cmd_wmask[d] = m;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (o_valid[d]) begin
                lat = i;
                break;
            end
        end
        if (!hold) cmd_valid[d] = 1'b0;
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s dut%0d: no response, required one within 40 cycles", name, d);
        end else begin
            chk({name, "_lat"},   d, 32'(lat),     32'(exp_lat));
            chk({name, "_rdata"}, d, o_rdata[d],   exp_q);
            chk({name, "_err"},   d, 32'(o_err[d]), 32'(exp_e));
        end
    endtask

    int b0, v0;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_addr[d]  = '0;
            cmd_read[d]  = 1'b0;
            cmd_wdata[d] = '0;
            cmd_wmask[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        cmd("wr10", 0, 32'h10, 0, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 2);
        cmd("rd10", 0, 32'h10, 1, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, 2);

        cmd("wr20",  0, 32'h20, 0, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 2);
        cmd("wr20m", 0, 32'h20, 0, 32'h11223344, 4'h5, 0, 32'h0, 0, 2);
        cmd("wr20z", 0, 32'h20, 0, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 0, 2);
        cmd("rd20",  0, 32'h20, 1, 32'h0, 4'h0, 0, 32'hDE22BE44, 0, 2);

        idle(1);
        cmd("wr40w3", 1, 32'h40, 0, 32'hA5A50F0F, 4'hF, 0, 32'h0, 0, 5);
        idle(1);
        b0 = bcnt[1];
        v0 = vcnt[1];
        cmd("rd40w3", 1, 32'h40, 1, 32'h0, 4'h0, 0, 32'hA5A50F0F, 0, 5);
        idle(2);
        chk("busy_cycles_w3", 1, 32'(bcnt[1] - b0), 32'd4);
        chk("strobe_len_w3",  1, 32'(vcnt[1] - v0), 32'd1);

        cmd("wr0", 0, 32'h0, 0, 32'h11110000, 4'hF, 0, 32'h0, 0, 2);
        cmd("wr4", 0, 32'h4, 0, 32'h22220001, 4'hF, 0, 32'h0, 0, 2);
        cmd("wr8", 0, 32'h8, 0, 32'h33330002, 4'hF, 0, 32'h0, 0, 2);
        idle(1);
        cmd("b2b0", 0, 32'h0, 1, 32'h0, 4'h0, 1, 32'h11110000, 0, 2);
        cmd("b2b4", 0, 32'h4, 1, 32'h0, 4'h0, 1, 32'h22220001, 0, 2);
        cmd("b2b8", 0, 32'h8, 1, 32'h0, 4'h0, 0, 32'h33330002, 0, 2);
        idle(1);

`ifdef VRB_SRAM_ERR_EN
        cmd("wr1000", 0, 32'h1000, 0, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1, 2);
        cmd("rd3",    0, 32'h3, 1, 32'h0, 4'h0, 0, 32'h0, 1, 2);
        cmd("rd0",    0, 32'h0, 1, 32'h0, 4'h0, 0, 32'h11110000, 0, 2);
`else
        cmd("wr1000", 0, 32'h1000, 0, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0, 2);
        cmd("rd3",    0, 32'h3, 1, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, 2);
        cmd("rd0",    0, 32'h0, 1, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, 2);
`endif

        idle(1);
        v0 = vcnt[1];
        cmd_valid[1] = 1'b1;
        cmd_addr[1]  = 32'h44;
        cmd_read[1]  = 1'b0;
        cmd_wdata[1] = 32'h5A5A5A5A;
        cmd_wmask[1] = 4'hF;
        idle(2);
        rst = 1'b1;
        cmd_valid[1] = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(6);
        chk("rsp_after_rst", 1, 32'(vcnt[1] - v0), 32'd0);
        cmd("rd44", 1, 32'h44, 1, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 0, 5);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
